mul_acc: RTL

Downstream accumulation stage for the registered 8x8 multiplier. It consumes one 16-bit product per beat and sums a stream of products, delimited by a `last` flag, into a wide accumulator. It presents the completed sum, the term count and an overflow flag through a valid/ready output register. Together with the multiplier it forms the dot-product datapath: operand pairs go into the multiplier, and this block turns its product stream into one result per vector.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_acc_if.sv | 32 +++
 rtl/mul_acc_sat_add.sv | 21 ++
 rtl/mul_acc.sv | 74 +++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, FSM states and datapath types for the multiply-accumulate path
package mul_pkg;

    localparam int PW_DEF = 16;
    localparam int AW_DEF = 24;
    localparam int CW_DEF = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [PW_DEF-1:0] prod_t;
    typedef logic [AW_DEF-1:0] sum_t;

endpackage

// File: rtl/mul_acc_if.sv
// rtl/mul_acc_if.sv - product input stream and result output register bundle
interface mul_acc_if
    import mul_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
);

    logic          in_valid;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_cnt;
    logic          out_ovf;

    // Upstream producer and downstream consumer side
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

endinterface

// File: rtl/mul_acc_sat_add.sv
// rtl/mul_acc_sat_add.sv - accumulator plus zero-extended product with carry-out and optional saturation
module sat_add #(
    parameter int PW  = 16,
    parameter int AW  = 24,
    parameter int SAT = 1
) (
    input  logic [AW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] full;

    // One extra bit catches the carry out of the AW-bit sum
    assign full  = {1'b0, a} + (AW+1)'(b);
    assign carry = full[AW];
    // Once saturated the sum is all-ones, and any further nonzero term carries again, so it sticks
    assign sum   = ((SAT != 0) && carry) ? {AW{1'b1}} : full[AW-1:0];

endmodule

// File: rtl/mul_acc.sv
// rtl/mul_acc.sv - sums a last-delimited product stream into one result per vector
module mul_acc
    import mul_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = CW_DEF,
    parameter int SAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    mul_acc_if.slave    bus
);

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [AW-1:0] add_sum;
    logic          add_carry;
    logic [CW-1:0] cnt_inc;
    logic          take;

    sat_add #(
        .PW  (PW),
        .AW  (AW),
        .SAT (SAT)
    ) u_add (
        .a     (acc),
        .b     (bus.in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Ready depends only on reset, the result register and the consumer, never on in_valid
    assign bus.in_ready  = !rst && ((state == ACC) || bus.out_ready);
    assign bus.out_valid = (state == HOLD);
    assign take          = bus.in_valid && bus.in_ready;
    assign cnt_inc       = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

    // FSM, running accumulator and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            bus.out_sum <= '0;
            bus.out_cnt <= '0;
            bus.out_ovf <= 1'b0;
        end else begin
            if ((state == HOLD) && bus.out_ready) begin
                state <= ACC;
            end
            if (take) begin
                if (bus.in_last) begin
                    // A last beat landing on a handoff cycle reloads HOLD with the new result
                    bus.out_sum <= add_sum;
                    bus.out_cnt <= cnt_inc;
                    bus.out_ovf <= ovf | add_carry;
                    state       <= HOLD;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                end else begin
                    acc <= add_sum;
                    cnt <= cnt_inc;
                    ovf <= ovf | add_carry;
                end
            end
        end
    end

endmodule
